// File: rtl/up_counter4.sv
// up_counter4: free-running WIDTH-bit up counter with synchronous reset,
// synchronous parallel load and a combinational terminal-count flag.
// Port order is kept as data_in, load, clk, reset, count, tc so that older
// positional instantiations still bind correctly.
module up_counter4 #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  // Reject widths outside the supported range at elaboration time.
  if (WIDTH < 2 || WIDTH > 16) begin : g_width_chk
    $error("up_counter4: WIDTH must be in 2..16");
  end

  // Counter register. Priority is reset, then load, then increment.
  // The increment wraps naturally at the register width.
  always_ff @(posedge clk) begin
    if (reset)     count <= '0;
    else if (load) count <= data_in;
    else           count <= count + CNT_ONE;
  end

  // Terminal count is decoded from the register only.
  always_comb begin
    tc = (count == CNT_MAX);
  end

endmodule

// File: tb/tb_up_counter4.sv
// Directed bench for up_counter4 (WIDTH=4). Inputs change 1 time unit after
// each rising edge; outputs are sampled at that same point, away from the edge.
module tb_up_counter4;

  logic [3:0] data_in;
  logic       load;
  logic       clk;
  logic       reset;
  logic [3:0] count;
  logic       tc;

  int n_cmp = 0;
  int n_err = 0;

  up_counter4 #(.WIDTH(4)) dut (
    .data_in (data_in),
    .load    (load),
    .clk     (clk),
    .reset   (reset),
    .count   (count),
    .tc      (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check both outputs against the expected count; tc is derived from it.
  task automatic chk_cnt(input string tag, input int exp);
    chk({tag, ".count"}, 16'(count), 16'(exp));
    chk({tag, ".tc"}, 16'(tc), (exp == 15) ? 16'd1 : 16'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1; load = 1'b0; tick();
    reset = 1'b0;
  endtask

  int exp_seq_a [5] = '{13, 14, 15, 0, 1};

  initial begin
    data_in = 4'd9; load = 1'b1; reset = 1'b1;
    #2;

    // Reset dominates a simultaneous load.
    tick();
    chk_cnt("rst_init", 0);
    reset = 1'b0; load = 1'b0;

    // Free count through wrap-around: 1..15,0,1..4 on 20 edges.
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_cnt($sformatf("run%0d", i), (i + 1) % 16);
    end

    // Load 13, then count through the wrap.
    do_reset();
    chk_cnt("rst_b", 0);
    data_in = 4'd13; load = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      load = 1'b0;
      chk_cnt($sformatf("ld13_%0d", i), exp_seq_a[i]);
    end

    // Count to 7, then reset and load on the same edge.
    do_reset();
    for (int i = 0; i < 7; i++) tick();
    chk_cnt("at7", 7);
    reset = 1'b1; load = 1'b1; data_in = 4'd9;
    tick();
    chk_cnt("rst_vs_ld", 0);
    reset = 1'b0; load = 1'b0;

    // Held load keeps the value; release resumes counting.
    data_in = 4'd5; load = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_cnt($sformatf("hold5_%0d", i), 5);
    end
    load = 1'b0;
    tick(); chk_cnt("rel6", 6);
    tick(); chk_cnt("rel7", 7);

    // From 10, hold reset for three edges, then release.
    data_in = 4'd10; load = 1'b1; tick(); load = 1'b0;
    chk_cnt("at10", 10);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_cnt($sformatf("rst_hold%0d", i), 0);
    end
    reset = 1'b0;
    tick(); chk_cnt("post_rst1", 1);
    tick(); chk_cnt("post_rst2", 2);

    // Load of the max value raises tc; next edge wraps to 0.
    data_in = 4'd15; load = 1'b1; tick(); load = 1'b0;
    chk_cnt("ld15", 15);
    tick(); chk_cnt("ld15_wrap", 0);

    // Toggle data_in/load between edges with load low at each edge.
    data_in = 4'd3; load = 1'b1; tick(); load = 1'b0;
    chk_cnt("at3", 3);
    for (int i = 0; i < 4; i++) begin
      #1 load = 1'b1; data_in = 4'(i * 5 + 1);
      #2 data_in = 4'd14;
      chk_cnt($sformatf("mid%0d", i), 3 + i);
      #1 load = 1'b0;
      tick();
      chk_cnt($sformatf("tog%0d", i), 4 + i);
    end

    // A reset pulse that does not span an edge is ignored.
    #2 reset = 1'b1;
    #3 reset = 1'b0;
    chk_cnt("rst_glitch_mid", 7);
    tick();
    chk_cnt("rst_glitch", 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global bound so the run always terminates.
  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
